// File: rtl/target_select_pkg.sv
// Shared state encoding, image dimensions and clamp helper for the
// multi-target colour selection controller.
package target_select_pkg;

    typedef enum logic [2:0] {
        INITIALIZE = 3'd0,
        SELECTED   = 3'd1,
        CONFIRMED  = 3'd2,
        MOVE       = 3'd3,
        PAUSE      = 3'd4
    } sel_state_t;

    localparam int FULL_W      = 640;
    localparam int FULL_H      = 480;
    localparam int HALF_W      = 320;
    localparam int HALF_H      = 240;
    localparam int MAX_TARGETS = 4;

    // Clamp a signed pixel coordinate into [0, hi].
    function automatic logic [11:0] clamp_coord(input logic signed [13:0] v,
                                                input logic        [11:0] hi);
        logic [11:0] r;
        if (v < 14'sd0) begin
            r = '0;
        end else if (v > $signed({2'b00, hi})) begin
            r = hi;
        end else begin
            r = v[11:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/window_averager.sv
// Averages an N x N pixel window per RGB444 channel; result registered one
// cycle after the window's last pixel.
module window_averager #(
    parameter int SAMPLE_LOG2 = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [10:0] hcount_i,
    input  logic [9:0]  vcount_i,
    input  logic [11:0] cam_i,
    input  logic        frame_start_i,
    input  logic [10:0] x0_i,
    input  logic [9:0]  y0_i,
    output logic [11:0] avg_o,
    output logic        done_o
);

    localparam int          N        = 1 << SAMPLE_LOG2;
    localparam int          AW       = 4 + 2 * SAMPLE_LOG2;
    localparam logic [11:0] WIN_LAST = 12'(N - 1);

    logic [2:0][AW-1:0] acc_q, sum;
    logic [11:0]        avg_q, avg_d;
    logic               done_q;
    logic               armed_q;
    logic [11:0]        px_x, px_y, wx0, wy0;
    logic               in_win, last_px;

    assign px_x = {1'b0, hcount_i};
    assign px_y = {2'b00, vcount_i};
    assign wx0  = {1'b0, x0_i};
    assign wy0  = {2'b00, y0_i};

    // Nothing is collected until a frame_start has been seen, so a reset in
    // mid-frame never produces a partial-window average.
    assign in_win  = armed_q
                   && (px_x >= wx0) && (px_x <= wx0 + WIN_LAST)
                   && (px_y >= wy0) && (px_y <= wy0 + WIN_LAST);
    assign last_px = (px_x == wx0 + WIN_LAST) && (px_y == wy0 + WIN_LAST);

    always_comb begin
        sum   = acc_q;
        avg_d = avg_q;
        for (int c = 0; c < 3; c++) begin
            sum[c]          = acc_q[c] + AW'(cam_i[4*c +: 4]);
            avg_d[4*c +: 4] = 4'(sum[c] >> (2 * SAMPLE_LOG2));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q   <= '0;
            avg_q   <= '0;
            done_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (frame_start_i) begin
                acc_q   <= '0;
                armed_q <= 1'b1;
            end else if (in_win) begin
                acc_q <= sum;
                if (last_px) begin
                    avg_q  <= avg_d;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign avg_o  = avg_q;
    assign done_o = done_q;

endmodule

// File: rtl/target_select_ctrl.sv
// Cursor motion, window colour sampling and the select/confirm/move state
// machine for up to four colour targets.
module target_select_ctrl
    import target_select_pkg::*;
#(
    parameter int NUM_TARGETS  = 2,
    parameter int SAMPLE_LOG2  = 1,
    parameter int CURSOR_STEP  = 3,
    parameter int ACCEL_FRAMES = 16
) (
    input  logic                      clk_65mhz,
    input  logic                      reset_n,
    input  logic [10:0]               hcount,
    input  logic [9:0]                vcount,
    input  logic [11:0]               cam,
    input  logic                      frame_start,
    input  logic                      dir_up,
    input  logic                      dir_down,
    input  logic                      dir_left,
    input  logic                      dir_right,
    input  logic                      confirm,
    input  logic                      activate,
    input  logic                      next_target,
    input  logic                      half_size,
    input  logic [6:0]                cur_rad,
    output logic [10:0]               cursor_x,
    output logic [9:0]                cursor_y,
    output logic [11:0]               sample_color,
    output logic                      sample_valid,
    output logic [1:0]                target_idx,
    output logic [12*NUM_TARGETS-1:0] goal_pixel,
    output logic [7*NUM_TARGETS-1:0]  goal_rad,
    output logic [NUM_TARGETS-1:0]    goal_valid,
    output logic [2:0]                state,
    output logic                      track,
    output logic                      move
);

    localparam int                HW        = $clog2(ACCEL_FRAMES + 2);
    localparam int                N         = 1 << SAMPLE_LOG2;
    localparam logic [HW-1:0]     HOLD_SAT  = HW'(ACCEL_FRAMES);
    localparam logic signed [13:0] STEP_SLOW = 14'(CURSOR_STEP);
    localparam logic signed [13:0] STEP_FAST = 14'(2 * CURSOR_STEP);
    localparam logic signed [13:0] HALF_N    = 14'(N / 2);
    localparam logic [1:0]        LAST_IDX  = 2'(NUM_TARGETS - 1);

    sel_state_t state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [NUM_TARGETS-1:0][11:0] pix_q, pix_d;
    logic [NUM_TARGETS-1:0][6:0]  rad_q, rad_d;
    logic [NUM_TARGETS-1:0]       valid_q, valid_d;
    logic track_q, track_d, move_q, move_d;
    logic conf_d1_q, act_d1_q, next_d1_q;
    logic conf_rise, act_rise, next_rise;

    logic [HW-1:0] hold_q, hold_d;
    logic [10:0]   cursor_x_q, cursor_x_d;
    logic [9:0]    cursor_y_q, cursor_y_d;
    logic signed [13:0] step, dx, dy;
    logic [11:0]   max_x, max_y;
    logic          any_dir, cursor_live;

    logic [10:0] win_x0;
    logic [9:0]  win_y0;
    logic [11:0] avg;
    logic        avg_done;
    logic        sample_valid_q;

    assign conf_rise = confirm & ~conf_d1_q;
    assign act_rise  = activate & ~act_d1_q;
    assign next_rise = next_target & ~next_d1_q;

    assign any_dir     = dir_up | dir_down | dir_left | dir_right;
    assign cursor_live = (state_q == INITIALIZE) || (state_q == SELECTED);
    assign max_x       = half_size ? 12'(HALF_W - 1) : 12'(FULL_W - 1);
    assign max_y       = half_size ? 12'(HALF_H - 1) : 12'(FULL_H - 1);

    // Clamping runs on every live frame_start, so a half_size change pulls a
    // stranded cursor back inside the smaller image even with no direction held.
    always_comb begin
        hold_d     = hold_q;
        cursor_x_d = cursor_x_q;
        cursor_y_d = cursor_y_q;
        step       = (hold_q >= HOLD_SAT) ? STEP_FAST : STEP_SLOW;
        dx         = '0;
        dy         = '0;
        if (dir_right && !dir_left) dx = step;
        else if (dir_left && !dir_right) dx = -step;
        if (dir_down && !dir_up) dy = step;
        else if (dir_up && !dir_down) dy = -step;
        if (frame_start) begin
            if (!any_dir) hold_d = '0;
            else if (hold_q < HOLD_SAT) hold_d = hold_q + HW'(1);
            if (cursor_live) begin
                cursor_x_d = 11'(clamp_coord($signed({3'b000, cursor_x_q}) + dx, max_x));
                cursor_y_d = 10'(clamp_coord($signed({4'b0000, cursor_y_q}) + dy, max_y));
            end
        end
    end

    // Window origin is centred on the cursor but kept fully inside the image.
    assign win_x0 = 11'(clamp_coord($signed({3'b000, cursor_x_q}) - HALF_N, max_x - 12'(N - 1)));
    assign win_y0 = 10'(clamp_coord($signed({4'b0000, cursor_y_q}) - HALF_N, max_y - 12'(N - 1)));

    window_averager #(
        .SAMPLE_LOG2(SAMPLE_LOG2)
    ) u_avg (
        .clk_i        (clk_65mhz),
        .rst_ni       (reset_n),
        .hcount_i     (hcount),
        .vcount_i     (vcount),
        .cam_i        (cam),
        .frame_start_i(frame_start),
        .x0_i         (win_x0),
        .y0_i         (win_y0),
        .avg_o        (avg),
        .done_o       (avg_done)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pix_d   = pix_q;
        rad_d   = rad_q;
        valid_d = valid_q;
        if (act_rise) begin
            state_d = INITIALIZE;
            idx_d   = '0;
            valid_d = '0;
        end else begin
            case (state_q)
                INITIALIZE: begin
                    if (conf_rise && sample_valid_q) begin
                        state_d = SELECTED;
                        for (int k = 0; k < NUM_TARGETS; k++) begin
                            if (idx_q == 2'(k)) pix_d[k] = avg;
                        end
                    end else if (next_rise) begin
                        idx_d = (idx_q == LAST_IDX) ? 2'd0 : idx_q + 2'd1;
                    end
                end
                SELECTED: begin
                    if (any_dir) begin
                        state_d = INITIALIZE;
                    end else if (conf_rise) begin
                        for (int k = 0; k < NUM_TARGETS; k++) begin
                            if (idx_q == 2'(k)) begin
                                rad_d[k]   = cur_rad;
                                valid_d[k] = 1'b1;
                            end
                        end
                        if (idx_q != LAST_IDX) begin
                            idx_d   = idx_q + 2'd1;
                            state_d = INITIALIZE;
                        end else begin
                            state_d = CONFIRMED;
                        end
                    end
                end
                CONFIRMED: if (!activate) state_d = MOVE;
                MOVE:      if (conf_rise) state_d = PAUSE;
                PAUSE:     if (conf_rise) state_d = MOVE;
                default:   state_d = INITIALIZE;
            endcase
        end
        track_d = (state_d == SELECTED) || (state_d == CONFIRMED) || (state_d == MOVE);
        move_d  = (state_d == MOVE);
    end

    always_ff @(posedge clk_65mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= INITIALIZE;
            idx_q          <= '0;
            pix_q          <= '0;
            rad_q          <= '0;
            valid_q        <= '0;
            track_q        <= 1'b0;
            move_q         <= 1'b0;
            conf_d1_q      <= 1'b0;
            act_d1_q       <= 1'b0;
            next_d1_q      <= 1'b0;
            hold_q         <= '0;
            cursor_x_q     <= 11'd15;
            cursor_y_q     <= 10'd15;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            pix_q          <= pix_d;
            rad_q          <= rad_d;
            valid_q        <= valid_d;
            track_q        <= track_d;
            move_q         <= move_d;
            conf_d1_q      <= confirm;
            act_d1_q       <= activate;
            next_d1_q      <= next_target;
            hold_q         <= hold_d;
            cursor_x_q     <= cursor_x_d;
            cursor_y_q     <= cursor_y_d;
            sample_valid_q <= sample_valid_q | avg_done;
        end
    end

    assign cursor_x     = cursor_x_q;
    assign cursor_y     = cursor_y_q;
    assign sample_color = avg;
    assign sample_valid = sample_valid_q;
    assign target_idx   = idx_q;
    assign goal_pixel   = pix_q;
    assign goal_rad     = rad_q;
    assign goal_valid   = valid_q;
    assign state        = state_q;
    assign track        = track_q;
    assign move         = move_q;

endmodule

// File: tb/tb_target_select_ctrl.sv
// Self-checking bench for target_select_ctrl: cursor, window sampling and
// target selection state machine against a behavioural model.
module tb_target_select_ctrl;

    localparam int NT    = 2;
    localparam int SL    = 1;
    localparam int N     = 2;
    localparam int STEP  = 3;
    localparam int ACCEL = 16;
    localparam logic [10:0] PARK_X = 11'd2000;
    localparam logic [9:0]  PARK_Y = 10'd1000;

    logic        clk_65mhz = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] hcount = PARK_X;
    logic [9:0]  vcount = PARK_Y;
    logic [11:0] cam = '0;
    logic        frame_start = 1'b0;
    logic        dir_up = 1'b0, dir_down = 1'b0, dir_left = 1'b0, dir_right = 1'b0;
    logic        confirm = 1'b0, activate = 1'b0, next_target = 1'b0;
    logic        half_size = 1'b0;
    logic [6:0]  cur_rad = '0;

    logic [10:0]        cursor_x;
    logic [9:0]         cursor_y;
    logic [11:0]        sample_color;
    logic               sample_valid;
    logic [1:0]         target_idx;
    logic [12*NT-1:0]   goal_pixel;
    logic [7*NT-1:0]    goal_rad;
    logic [NT-1:0]      goal_valid;
    logic [2:0]         state;
    logic               track, move;

    int checks = 0;
    int failures = 0;

    // Behavioural model of the cursor and the last window average.
    int          mx = 15, my = 15, mheld = 0;
    logic [11:0] m_sample = '0;

    target_select_ctrl #(
        .NUM_TARGETS (NT),
        .SAMPLE_LOG2 (SL),
        .CURSOR_STEP (STEP),
        .ACCEL_FRAMES(ACCEL)
    ) dut (
        .clk_65mhz   (clk_65mhz),
        .reset_n     (reset_n),
        .hcount      (hcount),
        .vcount      (vcount),
        .cam         (cam),
        .frame_start (frame_start),
        .dir_up      (dir_up),
        .dir_down    (dir_down),
        .dir_left    (dir_left),
        .dir_right   (dir_right),
        .confirm     (confirm),
        .activate    (activate),
        .next_target (next_target),
        .half_size   (half_size),
        .cur_rad     (cur_rad),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .sample_color(sample_color),
        .sample_valid(sample_valid),
        .target_idx  (target_idx),
        .goal_pixel  (goal_pixel),
        .goal_rad    (goal_rad),
        .goal_valid  (goal_valid),
        .state       (state),
        .track       (track),
        .move        (move)
    );

    always #5 clk_65mhz = ~clk_65mhz;

    task automatic tick();
        @(posedge clk_65mhz);
        #1;
    endtask

    task automatic drive_px(input int x, input int y, input logic [11:0] c);
        hcount = 11'(x);
        vcount = 10'(y);
        cam    = c;
        tick();
    endtask

    task automatic park();
        hcount = PARK_X;
        vcount = PARK_Y;
        cam    = '0;
    endtask

    // One frame_start with the given direction levels; updates the model.
    task automatic do_frame(input bit u, input bit d, input bit l, input bit r, input bit live);
        int st, w, h;
        dir_up = u; dir_down = d; dir_left = l; dir_right = r;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        dir_up = 1'b0; dir_down = 1'b0; dir_left = 1'b0; dir_right = 1'b0;
        st = (mheld >= ACCEL) ? 2 * STEP : STEP;
        mheld = (u | d | l | r) ? mheld + 1 : 0;
        w = half_size ? 320 : 640;
        h = half_size ? 240 : 480;
        if (live) begin
            if (r && !l) mx += st; else if (l && !r) mx -= st;
            if (d && !u) my += st; else if (u && !d) my -= st;
            mx = (mx < 0) ? 0 : ((mx > w - 1) ? w - 1 : mx);
            my = (my < 0) ? 0 : ((my > h - 1) ? h - 1 : my);
        end
    endtask

    // One frame with a raster over the window neighbourhood; win holds the
    // four window pixels, row-major from the window origin.
    task automatic sample_frame(input logic [47:0] win,
                                output logic [11:0] obs_before, output logic [11:0] obs_last,
                                output logic [11:0] obs_after, output logic [11:0] expv);
        int x0, y0, w, h, rs, gs, bs, xs;
        logic [11:0] px;
        do_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        w = half_size ? 320 : 640;
        h = half_size ? 240 : 480;
        x0 = mx - N / 2; x0 = (x0 < 0) ? 0 : ((x0 > w - N) ? w - N : x0);
        y0 = my - N / 2; y0 = (y0 < 0) ? 0 : ((y0 > h - N) ? h - N : y0);
        rs = 0; gs = 0; bs = 0;
        for (int i = 0; i < 4; i++) begin
            rs += int'(win[12*i+8 +: 4]);
            gs += int'(win[12*i+4 +: 4]);
            bs += int'(win[12*i +: 4]);
        end
        expv = {4'(rs / 4), 4'(gs / 4), 4'(bs / 4)};
        obs_before = 'x;
        obs_last   = 'x;
        xs = (x0 > 0) ? x0 - 1 : 0;
        for (int y = y0; y < y0 + N; y++) begin
            for (int x = xs; x <= x0 + N; x++) begin
                if (x >= x0 && x < x0 + N) px = win[12*((y - y0) * N + (x - x0)) +: 12];
                else px = 12'($urandom);
                drive_px(x, y, px);
                if (x == x0 && y == y0 + N - 1) obs_before = sample_color;
                if (x == x0 + N - 1 && y == y0 + N - 1) obs_last = sample_color;
            end
        end
        park();
        tick();
        obs_after = sample_color;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (cursor_x !== 11'd15 || cursor_y !== 10'd15) begin
            failures++; $display("FAIL reset_cursor: got %0d,%0d want 15,15", cursor_x, cursor_y);
        end
        checks++;
        if (state !== 3'd0 || target_idx !== 2'd0 || track !== 1'b0 || move !== 1'b0) begin
            failures++; $display("FAIL reset_fsm: got st=%0d idx=%0d tr=%b mv=%b want 0 0 0 0", state, target_idx, track, move);
        end
        checks++;
        if (goal_pixel !== '0 || goal_rad !== '0 || goal_valid !== '0) begin
            failures++; $display("FAIL reset_goals: got %h %h %b want zeros", goal_pixel, goal_rad, goal_valid);
        end
        checks++;
        if (sample_color !== 12'h000 || sample_valid !== 1'b0) begin
            failures++; $display("FAIL reset_sample: got %h %b want 000 0", sample_color, sample_valid);
        end
        reset_n = 1'b1;
        tick();
        mx = 15; my = 15; mheld = 0; m_sample = '0;
    endtask

    task automatic test_first_frame_gate();
        logic [11:0] ob, ol, oa, ev;
        drive_px(14, 14, 12'hF00);
        drive_px(15, 14, 12'h000);
        drive_px(14, 15, 12'h0F0);
        drive_px(15, 15, 12'h00F);
        park();
        tick();
        checks++;
        if (sample_valid !== 1'b0 || sample_color !== 12'h000) begin
            failures++; $display("FAIL gate_partial_frame: got %h %b want 000 0", sample_color, sample_valid);
        end
        sample_frame({12'h00F, 12'h0F0, 12'h000, 12'hF00}, ob, ol, oa, ev);
        checks++;
        if (ob !== 12'h000) begin
            failures++; $display("FAIL gate_before_last: got %h want 000", ob);
        end
        checks++;
        if (ol !== 12'h333 || ol !== ev) begin
            failures++; $display("FAIL gate_mixed_avg: got %h want 333", ol);
        end
        checks++;
        if (oa !== ev || sample_valid !== 1'b1) begin
            failures++; $display("FAIL gate_hold: got %h %b want %h 1", oa, sample_valid, ev);
        end
        m_sample = ev;
    endtask

    task automatic test_cursor_accel();
        for (int f = 0; f < 20; f++) begin
            do_frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            checks++;
            if (cursor_x !== 11'(mx) || cursor_y !== 10'(my)) begin
                failures++; $display("FAIL accel_frame%0d: got %0d,%0d want %0d,%0d", f, cursor_x, cursor_y, mx, my);
            end
        end
        checks++;
        if (cursor_x !== 11'd87 || cursor_y !== 10'd15) begin
            failures++; $display("FAIL accel_final: got %0d,%0d want 87,15", cursor_x, cursor_y);
        end
    endtask

    task automatic test_cursor_clamp();
        for (int f = 0; f < 120; f++) do_frame(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (cursor_x !== 11'd639 || cursor_y !== 10'd479) begin
            failures++; $display("FAIL clamp_max_full: got %0d,%0d want 639,479", cursor_x, cursor_y);
        end
        half_size = 1'b1;
        do_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (cursor_x !== 11'd319 || cursor_y !== 10'd239) begin
            failures++; $display("FAIL clamp_half_reclamp: got %0d,%0d want 319,239", cursor_x, cursor_y);
        end
        do_frame(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (cursor_x !== 11'd319 || cursor_y !== 10'd236) begin
            failures++; $display("FAIL clamp_opposing: got %0d,%0d want 319,236", cursor_x, cursor_y);
        end
        for (int f = 0; f < 120; f++) do_frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (cursor_x !== 11'd0 || cursor_y !== 10'd0) begin
            failures++; $display("FAIL clamp_min: got %0d,%0d want 0,0", cursor_x, cursor_y);
        end
    endtask

    task automatic test_sample_patterns();
        logic [11:0] ob, ol, oa, ev;
        sample_frame({4{12'h8C4}}, ob, ol, oa, ev);
        checks++;
        if (ol !== 12'h8C4 || oa !== 12'h8C4) begin
            failures++; $display("FAIL sample_corner_const: got %h/%h want 8c4", ol, oa);
        end
        checks++;
        if (ob !== m_sample) begin
            failures++; $display("FAIL sample_corner_early: got %h want %h", ob, m_sample);
        end
        m_sample = ev;
        sample_frame({12'h00F, 12'h0F0, 12'h000, 12'hF00}, ob, ol, oa, ev);
        checks++;
        if (ol !== 12'h333 || ob !== 12'h8C4) begin
            failures++; $display("FAIL sample_corner_mix: got %h (before %h) want 333 (before 8c4)", ol, ob);
        end
        m_sample = ev;
    endtask

    task automatic test_cursor_random();
        logic [11:0] ob, ol, oa, ev;
        bit u, d, l, r;
        for (int f = 0; f < 40; f++) begin
            u = ($urandom_range(0, 2) == 0);
            d = ($urandom_range(0, 2) == 0);
            l = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 7) == 0) half_size = ~half_size;
            do_frame(u, d, l, r, 1'b1);
            checks++;
            if (cursor_x !== 11'(mx) || cursor_y !== 10'(my)) begin
                failures++; $display("FAIL rand_cursor%0d: got %0d,%0d want %0d,%0d", f, cursor_x, cursor_y, mx, my);
            end
        end
        for (int s = 0; s < 3; s++) begin
            sample_frame({12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom)}, ob, ol, oa, ev);
            checks++;
            if (ol !== ev || oa !== ev || ob !== m_sample) begin
                failures++; $display("FAIL rand_sample%0d: got %h/%h (before %h) want %h (before %h)", s, ol, oa, ob, ev, m_sample);
            end
            m_sample = ev;
        end
    endtask

    task automatic test_fsm_sequence();
        logic [11:0] ob, ol, oa, ev, first_pix;
        activate = 1'b1;
        tick();
        checks++;
        if (state !== 3'd0 || target_idx !== 2'd0) begin
            failures++; $display("FAIL seq_activate_init: got st=%0d idx=%0d want 0 0", state, target_idx);
        end
        confirm = 1'b1; tick();
        checks++;
        if (state !== 3'd1 || track !== 1'b1 || goal_pixel[11:0] !== m_sample) begin
            failures++; $display("FAIL seq_select0: got st=%0d tr=%b pix=%h want 1 1 %h", state, track, goal_pixel[11:0], m_sample);
        end
        first_pix = m_sample;
        confirm = 1'b0; tick();
        cur_rad = 7'd20; confirm = 1'b1; tick();
        checks++;
        if (state !== 3'd0 || target_idx !== 2'd1 || goal_valid !== 2'b01 || goal_rad[6:0] !== 7'd20 || track !== 1'b0) begin
            failures++; $display("FAIL seq_confirm0: got st=%0d idx=%0d v=%b rad=%0d tr=%b want 0 1 01 20 0", state, target_idx, goal_valid, goal_rad[6:0], track);
        end
        confirm = 1'b0; tick();
        sample_frame({12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom)}, ob, ol, oa, ev);
        m_sample = ev;
        confirm = 1'b1; tick();
        checks++;
        if (state !== 3'd1 || goal_pixel[23:12] !== ev || goal_pixel[11:0] !== first_pix) begin
            failures++; $display("FAIL seq_select1: got st=%0d pix=%h want 1 %h%h", state, goal_pixel, ev, first_pix);
        end
        confirm = 1'b0; tick();
        cur_rad = 7'd35; confirm = 1'b1; tick();
        checks++;
        if (state !== 3'd2 || goal_valid !== 2'b11 || goal_rad !== {7'd35, 7'd20} || track !== 1'b1 || move !== 1'b0 || target_idx !== 2'd1) begin
            failures++; $display("FAIL seq_confirmed: got st=%0d v=%b rad=%h tr=%b mv=%b want 2 11 %h 1 0", state, goal_valid, goal_rad, track, move, {7'd35, 7'd20});
        end
        confirm = 1'b0; tick();
        checks++;
        if (state !== 3'd2) begin
            failures++; $display("FAIL seq_hold_confirmed: got %0d want 2", state);
        end
        activate = 1'b0; tick();
        checks++;
        if (state !== 3'd3 || move !== 1'b1 || track !== 1'b1) begin
            failures++; $display("FAIL seq_move: got st=%0d mv=%b tr=%b want 3 1 1", state, move, track);
        end
        do_frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (cursor_x !== 11'(mx) || cursor_y !== 10'(my)) begin
            failures++; $display("FAIL seq_cursor_frozen: got %0d,%0d want %0d,%0d", cursor_x, cursor_y, mx, my);
        end
        confirm = 1'b1; tick();
        checks++;
        if (state !== 3'd4 || move !== 1'b0 || track !== 1'b0) begin
            failures++; $display("FAIL seq_pause: got st=%0d mv=%b tr=%b want 4 0 0", state, move, track);
        end
        confirm = 1'b0; tick();
        confirm = 1'b1; tick();
        checks++;
        if (state !== 3'd3 || move !== 1'b1) begin
            failures++; $display("FAIL seq_resume: got st=%0d mv=%b want 3 1", state, move);
        end
        confirm = 1'b0; tick();
    endtask

    task automatic test_selected_dir_priority();
        activate = 1'b1; tick();
        checks++;
        if (state !== 3'd0 || target_idx !== 2'd0 || goal_valid !== 2'b00 || goal_rad !== {7'd35, 7'd20} || track !== 1'b0 || move !== 1'b0) begin
            failures++; $display("FAIL prio_activate_move: got st=%0d idx=%0d v=%b rad=%h want 0 0 00 keep", state, target_idx, goal_valid, goal_rad);
        end
        next_target = 1'b1; tick();
        checks++;
        if (target_idx !== 2'd1) begin
            failures++; $display("FAIL next_target_inc: got %0d want 1", target_idx);
        end
        next_target = 1'b0; tick();
        next_target = 1'b1; tick();
        checks++;
        if (target_idx !== 2'd0) begin
            failures++; $display("FAIL next_target_wrap: got %0d want 0", target_idx);
        end
        next_target = 1'b0; tick();
        confirm = 1'b1; tick();
        confirm = 1'b0; tick();
        cur_rad = 7'd50; dir_up = 1'b1; confirm = 1'b1; tick();
        checks++;
        if (state !== 3'd0 || goal_valid !== 2'b00 || goal_rad[6:0] !== 7'd20 || target_idx !== 2'd0) begin
            failures++; $display("FAIL prio_dir_over_confirm: got st=%0d v=%b rad=%0d idx=%0d want 0 00 20 0", state, goal_valid, goal_rad[6:0], target_idx);
        end
        dir_up = 1'b0; confirm = 1'b0; tick();
    endtask

    task automatic test_activate_and_reset();
        activate = 1'b0; tick();
        for (int k = 0; k < 4; k++) begin
            cur_rad = 7'(10 + k);
            confirm = 1'b1; tick();
            confirm = 1'b0; tick();
        end
        checks++;
        if (state !== 3'd3 || move !== 1'b1 || goal_rad !== {7'd13, 7'd11}) begin
            failures++; $display("FAIL prio_reach_move: got st=%0d mv=%b rad=%h want 3 1 %h", state, move, goal_rad, {7'd13, 7'd11});
        end
        activate = 1'b1; confirm = 1'b1; tick();
        checks++;
        if (state !== 3'd0 || target_idx !== 2'd0 || goal_valid !== 2'b00 || track !== 1'b0 || move !== 1'b0) begin
            failures++; $display("FAIL prio_activate_confirm: got st=%0d idx=%0d v=%b tr=%b mv=%b want 0 0 00 0 0", state, target_idx, goal_valid, track, move);
        end
        confirm = 1'b0;
        drive_px(100, 50, 12'hABC);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (cursor_x !== 11'd15 || cursor_y !== 10'd15 || state !== 3'd0 || track !== 1'b0 || move !== 1'b0) begin
            failures++; $display("FAIL async_reset_fsm: got %0d,%0d st=%0d tr=%b mv=%b want 15,15 0 0 0", cursor_x, cursor_y, state, track, move);
        end
        checks++;
        if (goal_pixel !== '0 || goal_rad !== '0 || goal_valid !== '0 || sample_color !== '0 || sample_valid !== 1'b0) begin
            failures++; $display("FAIL async_reset_data: got %h %h %b %h %b want zeros", goal_pixel, goal_rad, goal_valid, sample_color, sample_valid);
        end
        park();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_first_frame_gate();
        test_cursor_accel();
        test_cursor_clamp();
        test_sample_patterns();
        test_cursor_random();
        half_size = 1'b0;
        test_fsm_sequence();
        test_selected_dir_priority();
        test_activate_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
